// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard controller
package hazard_pkg;
   typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;
   localparam int X0 = 0;
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register busy bits for in-flight mul/div results
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          set_en,
   input  logic [AW-1:0] set_addr,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_addr,
   input  logic [AW-1:0] rd1_addr,
   input  logic [AW-1:0] rd2_addr,
   input  logic [AW-1:0] waw_addr,
   output logic          rd1_busy,
   output logic          rd2_busy,
   output logic          waw_busy
);
   logic [NREGS-1:0] busy, busy_nxt;
   // set is applied after clear so a back-to-back issue to the same rd stays busy
   always_comb begin
      busy_nxt = busy;
      if (clr_en) busy_nxt[clr_addr] = 1'b0;
      if (set_en && set_addr != AW'(X0)) busy_nxt[set_addr] = 1'b1;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) busy <= '0;
      else busy <= busy_nxt;
   assign rd1_busy = busy[rd1_addr];
   assign rd2_busy = busy[rd2_addr];
   assign waw_busy = busy[waw_addr];
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use/scoreboard/mul-div stalls, branch flush and perf counters
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int AW    = 5,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    id_rs1_addr,
   input  logic [AW-1:0]    id_rs2_addr,
   input  logic [AW-1:0]    id_rd_addr,
   input  logic             id_regwrite,
   input  logic             id_md_op,
   input  logic [AW-1:0]    id_ex_rs1_addr,
   input  logic [AW-1:0]    id_ex_rs2_addr,
   input  logic [AW-1:0]    ex_rd_addr,
   input  logic             ex_mem_read,
   input  logic             ex_md_start,
   input  logic             ex_branch_taken,
   input  logic [AW-1:0]    ex_mem_rd_addr,
   input  logic             ex_mem_regwrite,
   input  logic [AW-1:0]    mem_wb_rd_addr,
   input  logic             mem_wb_regwrite,
   input  logic             md_done,
   input  logic [AW-1:0]    md_rd_addr,
   output logic [1:0]       forward_a,
   output logic [1:0]       forward_b,
   output logic             stallF,
   output logic             stallD,
   output logic             flushD,
   output logic             flushE,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);
   md_state_t state;
   logic rs1_busy, rs2_busy, rd_busy, lw_stall, sb_stall, md_stall, any_stall;

   function automatic fwd_sel_t fwd(input logic [AW-1:0] src);
      return (ex_mem_regwrite && ex_mem_rd_addr != AW'(X0) && ex_mem_rd_addr == src) ? FWD_MEM :
             (mem_wb_regwrite && mem_wb_rd_addr != AW'(X0) && mem_wb_rd_addr == src) ? FWD_WB : FWD_RF;
   endfunction

   assign forward_a = fwd(id_ex_rs1_addr);
   assign forward_b = fwd(id_ex_rs2_addr);

   hazard_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
      .clk(clk), .rst(rst),
      .set_en(ex_md_start), .set_addr(ex_rd_addr),
      .clr_en(md_done), .clr_addr(md_rd_addr),
      .rd1_addr(id_rs1_addr), .rd2_addr(id_rs2_addr), .waw_addr(id_rd_addr),
      .rd1_busy(rs1_busy), .rd2_busy(rs2_busy), .waw_busy(rd_busy)
   );

   assign lw_stall  = ex_mem_read && ex_rd_addr != AW'(X0) &&
                      (ex_rd_addr == id_rs1_addr || ex_rd_addr == id_rs2_addr);
   assign sb_stall  = rs1_busy | rs2_busy | (id_regwrite & rd_busy);
   assign md_stall  = id_md_op & md_busy & ~md_done;
   assign any_stall = lw_stall | sb_stall | md_stall;

   // a taken branch makes the ID instruction wrong-path, so flushing beats stalling
   assign stallF = any_stall & ~ex_branch_taken;
   assign stallD = any_stall & ~ex_branch_taken;
   assign flushD = ex_branch_taken;
   assign flushE = ex_branch_taken | any_stall;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else if (state == IDLE) state <= ex_md_start ? BUSY : IDLE;
      else state <= (md_done && !ex_md_start) ? IDLE : BUSY;
   assign md_busy = state == BUSY;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stallD && ~&stall_count) stall_count <= stall_count + CNT_W'(1);
         if (ex_branch_taken && ~&flush_count) flush_count <= flush_count + CNT_W'(1);
      end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
   logic clk = 1'b0, rst = 1'b1;
   logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr, id_ex_rs1_addr, id_ex_rs2_addr;
   logic [4:0] ex_rd_addr, ex_mem_rd_addr, mem_wb_rd_addr, md_rd_addr;
   logic id_regwrite, id_md_op, ex_mem_read, ex_md_start, ex_branch_taken;
   logic ex_mem_regwrite, mem_wb_regwrite, md_done;
   logic [1:0] forward_a, forward_b, s_fa, s_fb;
   logic stallF, stallD, flushD, flushE, md_busy;
   logic s_stallF, s_stallD, s_flushD, s_flushE, s_md_busy;
   logic [31:0] stall_count, flush_count;
   logic [3:0] s_sc, s_fc;
   int checks = 0, failures = 0;
   logic [31:0] busy_m;
   logic md_busy_m;
   logic [4:0] md_rd_m;
   int sc_m, fc_m;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk(clk), .rst(rst), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rd_addr(id_rd_addr), .id_regwrite(id_regwrite), .id_md_op(id_md_op),
      .id_ex_rs1_addr(id_ex_rs1_addr), .id_ex_rs2_addr(id_ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
      .ex_mem_read(ex_mem_read), .ex_md_start(ex_md_start), .ex_branch_taken(ex_branch_taken),
      .ex_mem_rd_addr(ex_mem_rd_addr), .ex_mem_regwrite(ex_mem_regwrite),
      .mem_wb_rd_addr(mem_wb_rd_addr), .mem_wb_regwrite(mem_wb_regwrite), .md_done(md_done),
      .md_rd_addr(md_rd_addr), .forward_a(forward_a), .forward_b(forward_b), .stallF(stallF),
      .stallD(stallD), .flushD(flushD), .flushE(flushE), .md_busy(md_busy),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   hazard_ctrl #(.CNT_W(4)) u_small (
      .clk(clk), .rst(rst), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rd_addr(id_rd_addr), .id_regwrite(id_regwrite), .id_md_op(id_md_op),
      .id_ex_rs1_addr(id_ex_rs1_addr), .id_ex_rs2_addr(id_ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
      .ex_mem_read(ex_mem_read), .ex_md_start(ex_md_start), .ex_branch_taken(ex_branch_taken),
      .ex_mem_rd_addr(ex_mem_rd_addr), .ex_mem_regwrite(ex_mem_regwrite),
      .mem_wb_rd_addr(mem_wb_rd_addr), .mem_wb_regwrite(mem_wb_regwrite), .md_done(md_done),
      .md_rd_addr(md_rd_addr), .forward_a(s_fa), .forward_b(s_fb), .stallF(s_stallF),
      .stallD(s_stallD), .flushD(s_flushD), .flushE(s_flushE), .md_busy(s_md_busy),
      .stall_count(s_sc), .flush_count(s_fc)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] exp_fwd(input logic [4:0] src);
      if (ex_mem_regwrite && ex_mem_rd_addr != 0 && ex_mem_rd_addr == src) return 2'b10;
      if (mem_wb_regwrite && mem_wb_rd_addr != 0 && mem_wb_rd_addr == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic exp_hazard();
      logic lw = ex_mem_read && ex_rd_addr != 0 && (ex_rd_addr == id_rs1_addr || ex_rd_addr == id_rs2_addr);
      logic sb = busy_m[id_rs1_addr] || busy_m[id_rs2_addr] || (id_regwrite && busy_m[id_rd_addr]);
      logic md = id_md_op && md_busy_m && !md_done;
      return lw || sb || md;
   endfunction

   function automatic int sat4(input int v);
      return v > 15 ? 15 : v;
   endfunction

   always @(negedge clk) begin
      logic hz, st;
      if (rst) begin
         busy_m = '0;
         md_busy_m = 1'b0;
         sc_m = 0;
         fc_m = 0;
      end
      hz = exp_hazard();
      st = hz && !ex_branch_taken;
      chk("forward_a", forward_a, exp_fwd(id_ex_rs1_addr));
      chk("forward_b", forward_b, exp_fwd(id_ex_rs2_addr));
      chk("stallF", stallF, st);
      chk("stallD", stallD, st);
      chk("flushD", flushD, ex_branch_taken);
      chk("flushE", flushE, hz || ex_branch_taken);
      chk("md_busy", md_busy, md_busy_m);
      chk("stall_count", stall_count, sc_m);
      chk("flush_count", flush_count, fc_m);
      chk("s_forward_a", s_fa, exp_fwd(id_ex_rs1_addr));
      chk("s_forward_b", s_fb, exp_fwd(id_ex_rs2_addr));
      chk("s_stall_flush", {s_stallF, s_stallD, s_flushD, s_flushE, s_md_busy},
          {st, st, ex_branch_taken, hz || ex_branch_taken, md_busy_m});
      chk("s_stall_count", s_sc, sat4(sc_m));
      chk("s_flush_count", s_fc, sat4(fc_m));
      chk("md_protocol", md_busy_m && ex_md_start && !md_done, 1'b0);
      if (!rst) begin
         if (st) sc_m++;
         if (ex_branch_taken) fc_m++;
         if (md_done) busy_m[md_rd_addr] = 1'b0;
         if (ex_md_start && ex_rd_addr != 0) busy_m[ex_rd_addr] = 1'b1;
         if (ex_md_start) md_rd_m = ex_rd_addr;
         md_busy_m = ex_md_start ? 1'b1 : md_done ? 1'b0 : md_busy_m;
      end
   end

   task automatic idle();
      {id_rs1_addr, id_rs2_addr, id_rd_addr, id_ex_rs1_addr, id_ex_rs2_addr} = '0;
      {ex_rd_addr, ex_mem_rd_addr, mem_wb_rd_addr, md_rd_addr} = '0;
      {id_regwrite, id_md_op, ex_mem_read, ex_md_start, ex_branch_taken} = '0;
      {ex_mem_regwrite, mem_wb_regwrite, md_done} = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1 chk("rst_md_busy", md_busy, 1'b0);
      chk("rst_stall_count", stall_count, 0);
      step(); ex_mem_rd_addr = 5; ex_mem_regwrite = 1; mem_wb_rd_addr = 5; mem_wb_regwrite = 1;
      id_ex_rs1_addr = 5; #1 chk("fwd_mem", forward_a, 2'b10);
      step(); ex_mem_regwrite = 0; #1 chk("fwd_wb", forward_a, 2'b01);
      step(); ex_mem_rd_addr = 0; mem_wb_rd_addr = 0; ex_mem_regwrite = 1; id_ex_rs1_addr = 0;
      #1 chk("fwd_x0", forward_a, 2'b00);
      step(); idle(); ex_mem_read = 1; ex_rd_addr = 7; id_rs2_addr = 7;
      #1 chk("lw_stall", {stallF, stallD, flushE, flushD}, 4'b1110);
      step(); ex_rd_addr = 0; #1 chk("lw_x0_nostall", stallD, 1'b0);
      chk("lw_count", stall_count, 1);
      step(); idle(); ex_md_start = 1; ex_rd_addr = 9; #1 chk("md_start_idle", md_busy, 1'b0);
      step(); idle(); id_rs1_addr = 9; #1 chk("sb_raw_stall", {md_busy, stallD}, 2'b11);
      repeat (2) step();
      step(); md_done = 1; md_rd_addr = 9; #1 chk("sb_done_cycle", stallD, 1'b1);
      step(); md_done = 0; #1 chk("sb_released", {md_busy, stallD}, 2'b00);
      chk("sb_count", stall_count, 5);
      step(); idle(); ex_md_start = 1; ex_rd_addr = 3;
      step(); idle(); id_md_op = 1; #1 chk("md_struct_stall", stallD, 1'b1);
      step(); idle(); md_done = 1; md_rd_addr = 3; ex_md_start = 1; ex_rd_addr = 3; id_md_op = 1;
      #1 chk("md_done_nostall", stallD, 1'b0);
      step(); idle(); id_rs1_addr = 3; #1 chk("b2b_busy", {md_busy, stallD}, 2'b11);
      step(); ex_branch_taken = 1;
      #1 chk("br_flush", {flushD, flushE, stallD, stallF}, 4'b1100);
      chk("br_flush_count_pre", flush_count, 0);
      step(); ex_branch_taken = 0; #1 chk("br_flush_count", flush_count, 1);
      chk("br_stall_count", stall_count, 7);
      step(); idle(); md_done = 1; md_rd_addr = 3;
      step(); idle(); #1 chk("b2b_idle", md_busy, 1'b0);
      chk("pre_sat_count", stall_count, 8);
      step(); ex_mem_read = 1; ex_rd_addr = 4; id_rs1_addr = 4;
      repeat (19) step();
      step(); idle(); #1 chk("sat_big", stall_count, 28);
      chk("sat_small", s_sc, 4'hF);
      step(); idle(); ex_md_start = 1; ex_rd_addr = 9;
      step(); idle(); id_rs1_addr = 9; #1 chk("pre_rst_busy", {md_busy, stallD}, 2'b11);
      #1 rst = 1'b1;
      #1 chk("async_rst_busy", {md_busy, stallD, s_md_busy}, 3'b000);
      chk("async_rst_stall_count", stall_count, 0);
      chk("async_rst_flush_count", flush_count, 0);
      step(); rst = 1'b0; idle();
      repeat (3000) begin
         step();
         rst = $urandom_range(0, 399) == 0;
         id_rs1_addr = 5'($urandom_range(0, 7));
         id_rs2_addr = 5'($urandom_range(0, 7));
         id_rd_addr = 5'($urandom_range(0, 7));
         id_ex_rs1_addr = 5'($urandom_range(0, 7));
         id_ex_rs2_addr = 5'($urandom_range(0, 7));
         ex_rd_addr = 5'($urandom_range(0, 7));
         ex_mem_rd_addr = 5'($urandom_range(0, 7));
         mem_wb_rd_addr = 5'($urandom_range(0, 7));
         id_regwrite = 1'($urandom);
         ex_mem_regwrite = 1'($urandom);
         mem_wb_regwrite = 1'($urandom);
         id_md_op = $urandom_range(0, 3) == 0;
         ex_mem_read = $urandom_range(0, 2) == 0;
         ex_branch_taken = $urandom_range(0, 9) == 0;
         md_done = md_busy_m && $urandom_range(0, 3) == 0;
         md_rd_addr = md_done ? md_rd_m : 5'($urandom_range(0, 7));
         ex_md_start = (!md_busy_m || md_done) && $urandom_range(0, 5) == 0;
      end
      step(); rst = 1'b0; idle();
      @(negedge clk);
      #1 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
